// File: rtl/vram_pattern_filler.sv
// Pattern-fill engine: paints an H_RES x V_RES frame with a tiled two-colour pattern, one write per accepted cycle.
// Optional frame border in ~colour A is enabled by defining VRAM_FILLER_BORDER_EN.
module vram_pattern_filler #(
  parameter int H_RES     = 256,
  parameter int V_RES     = 256,
  parameter int TILE_LOG2 = 6,
  parameter int COLOR_W   = 3,
  parameter int ADDR_W    = 16
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iStart,
  input  logic [1:0]         iMode,
  input  logic [COLOR_W-1:0] iColorA,
  input  logic [COLOR_W-1:0] iColorB,
  input  logic               iWrReady,
  output logic               oWrEnable,
  output logic [ADDR_W-1:0]  oWrAddress,
  output logic [COLOR_W-1:0] oWrColor,
  output logic               oBusy,
  output logic               oDone,
  output logic [1:0]         dbg_state
);

  localparam int CW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int RW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(H_RES - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(V_RES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CW-1:0]      col;
  logic [RW-1:0]      row;
  logic [1:0]         mode_r;
  logic [COLOR_W-1:0] color_a;
  logic [COLOR_W-1:0] color_b;
  logic               filling;
  logic               accept;
  logic               col_last;
  logic               row_last;
  logic               tc0;
  logic               tr0;
  logic               parity;
  logic [COLOR_W-1:0] pixel;

  // Handshake: a write transfers on any rising edge where oWrEnable and iWrReady are both high;
  // while iWrReady is low the address/colour hold because they derive only from the counters.
  assign filling  = (state == FILL);
  assign accept   = filling && iWrReady;
  assign col_last = (col == COL_MAX);
  assign row_last = (row == ROW_MAX);
  assign dbg_state = state;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      col     <= '0;
      row     <= '0;
      mode_r  <= 2'd0;
      color_a <= '0;
      color_b <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && iStart) begin
        mode_r  <= iMode;
        color_a <= iColorA;
        color_b <= iColorB;
        col     <= '0;
        row     <= '0;
      end else if (accept) begin
        // Row counter is exactly log2(V_RES) wide, so it wraps to 0 after the last pixel.
        col <= col_last ? '0 : col + CW'(1);
        if (col_last) row <= row + RW'(1);
      end
    end
  end

  always_comb begin
    state_next = state;
    oWrEnable  = 1'b0;
    oBusy      = 1'b0;
    oDone      = 1'b0;
    case (state)
      IDLE: if (iStart) state_next = FILL;
      FILL: begin
        oWrEnable = 1'b1;
        oBusy     = 1'b1;
        if (accept && col_last && row_last) state_next = DONE;
      end
      DONE: begin
        oDone      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Tile index LSBs; a tile as wide as the frame leaves the index constant 0.
  generate
    if (TILE_LOG2 < CW) begin : g_tc
      assign tc0 = col[TILE_LOG2];
    end else begin : g_tc_zero
      assign tc0 = 1'b0;
    end
    if (TILE_LOG2 < RW) begin : g_tr
      assign tr0 = row[TILE_LOG2];
    end else begin : g_tr_zero
      assign tr0 = 1'b0;
    end
  endgenerate

  always_comb begin
    parity = 1'b0;
    case (mode_r)
      2'd0:    parity = tc0 ^ tr0;
      2'd1:    parity = tc0;
      2'd2:    parity = tr0;
      default: parity = 1'b0;
    endcase
    pixel = parity ? color_b : color_a;
`ifdef VRAM_FILLER_BORDER_EN
    if (col == '0 || col_last || row == '0 || row_last) pixel = ~color_a;
`endif
    oWrColor   = filling ? pixel : '0;
    oWrAddress = filling ? ADDR_W'({row, col}) : '0;
  end

endmodule

// File: tb/tb_vram_pattern_filler.sv
// Randomized bench for vram_pattern_filler on a reduced 64x32 frame with 8x8 tiles,
// checked against a per-pixel arithmetic model of the pattern rules.
module tb_vram_pattern_filler;

  localparam int H  = 64;
  localparam int V  = 32;
  localparam int TL = 3;
  localparam int CW = 3;
  localparam int AW = 12;
  localparam int N  = H * V;
  localparam int PW = AW + CW;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          iStart = 1'b0;
  logic [1:0]    iMode = 2'd0;
  logic [CW-1:0] iColorA = '0;
  logic [CW-1:0] iColorB = '0;
  logic          iWrReady = 1'b1;
  logic          oWrEnable;
  logic [AW-1:0] oWrAddress;
  logic [CW-1:0] oWrColor;
  logic          oBusy;
  logic          oDone;
  logic [1:0]    dbg_state;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int accept_cnt = 0;
  int edge_cnt = 0;
  bit rnd_ready = 1'b0;
  bit stall_pend = 1'b0;
  logic [PW:0]   stall_snap;
  logic [PW-1:0] exp_q[$];

  vram_pattern_filler #(
    .H_RES(H), .V_RES(V), .TILE_LOG2(TL), .COLOR_W(CW), .ADDR_W(AW)
  ) dut (
    .Clock(Clock), .Reset(Reset), .iStart(iStart), .iMode(iMode),
    .iColorA(iColorA), .iColorB(iColorB), .iWrReady(iWrReady),
    .oWrEnable(oWrEnable), .oWrAddress(oWrAddress), .oWrColor(oWrColor),
    .oBusy(oBusy), .oDone(oDone), .dbg_state(dbg_state)
  );

  // Clock / edge counter
  always #5 Clock = ~Clock;
  always @(posedge Clock) edge_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] model_color(input logic [1:0] mode, input logic [CW-1:0] a,
                                                input logic [CW-1:0] b, input int r, input int c);
    int tc = c / (1 << TL);
    int tr = r / (1 << TL);
    int p;
    case (mode)
      2'd0:    p = (tc + tr) % 2;
      2'd1:    p = tc % 2;
      2'd2:    p = tr % 2;
      default: p = 0;
    endcase
    model_color = (p == 1) ? b : a;
`ifdef VRAM_FILLER_BORDER_EN
    if (r == 0 || r == V - 1 || c == 0 || c == H - 1) model_color = ~a;
`endif
  endfunction

  // Scoreboard / monitor: sampled on the falling edge, away from the active edge.
  always @(negedge Clock) begin
    if (Reset) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend)
        check("stall_hold", 32'({oWrEnable, oWrAddress, oWrColor}), 32'(stall_snap));
      stall_pend = 1'b0;
      if (oWrEnable || oBusy) check("busy_eq_enable", 32'(oBusy), 32'(oWrEnable));
      if (oWrEnable && iWrReady) begin
        accept_cnt++;
        if (exp_q.size() == 0) check("unexpected_write", 32'(oWrAddress) | 32'h8000_0000, 32'(oWrAddress));
        else check("write_addr_color", 32'({oWrAddress, oWrColor}), 32'(exp_q.pop_front()));
      end else if (oWrEnable) begin
        stall_pend = 1'b1;
        stall_snap = {oWrEnable, oWrAddress, oWrColor};
      end
      if (oDone) done_cnt++;
    end
  end

  // Ready driver: random 50% duty when enabled, otherwise held high.
  initial begin
    forever begin
      @(posedge Clock);
      #1;
      iWrReady = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic start_fill(input logic [1:0] mode, input logic [CW-1:0] a, input logic [CW-1:0] b,
                            input bit rnd, output int s);
    exp_q.delete();
    for (int r = 0; r < V; r++)
      for (int c = 0; c < H; c++)
        exp_q.push_back({AW'(r * H + c), model_color(mode, a, b, r, c)});
    rnd_ready = rnd;
    accept_cnt = 0;
    repeat (2) @(negedge Clock);
    iMode = mode; iColorA = a; iColorB = b; iStart = 1'b1;
    @(posedge Clock);
    #1;
    s = edge_cnt;
    iStart = 1'b0;
    check("first_write_valid", 32'(oWrEnable), 32'd1);
    check("first_write_addr", 32'(oWrAddress), 32'd0);
  endtask

  task automatic run_fill(input logic [1:0] mode, input logic [CW-1:0] a, input logic [CW-1:0] b,
                          input bit rnd, input bit disturb, input bit start_at_done);
    int s;
    int d0;
    bit seen = 1'b0;
    d0 = done_cnt;
    start_fill(mode, a, b, rnd, s);
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(negedge Clock);
      iStart = 1'b0;
      if (oDone) seen = 1'b1;
      else if (disturb && oBusy) begin
        iMode = 2'($urandom); iColorA = CW'($urandom); iColorB = CW'($urandom);
        iStart = ($urandom_range(0, 3) == 0);
      end
    end
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      if (!rnd) check("done_latency", 32'(edge_cnt - s), 32'(N));
      check("writes_left", 32'(exp_q.size()), 32'd0);
      check("done_busy_low", 32'({oBusy, oWrEnable}), 32'd0);
      if (start_at_done) iStart = 1'b1;
      @(negedge Clock);
      iStart = 1'b0;
      check("done_one_cycle", 32'(oDone), 32'd0);
      check("idle_after_done", 32'({oWrEnable, oBusy}), 32'd0);
      repeat (4) @(negedge Clock);
      check("idle_stays", 32'({oWrEnable, oBusy, oDone}), 32'd0);
      check("done_count", 32'(done_cnt - d0), 32'd1);
    end
    rnd_ready = 1'b0;
  endtask

  initial begin
    int s;
    int d0;
    #1;
    check("reset_outputs", 32'({oWrEnable, oWrAddress, oWrColor, oBusy, oDone}), 32'd0);
    repeat (3) @(negedge Clock);
    Reset = 1'b0;
    repeat (100) begin
      @(negedge Clock);
      check("idle_outputs", 32'({oWrEnable, oWrAddress, oWrColor, oBusy, oDone}), 32'd0);
    end

    run_fill(2'd0, 3'b111, 3'b110, 1'b0, 1'b0, 1'b0);
    run_fill(2'd1, 3'b111, 3'b110, 1'b1, 1'b1, 1'b0);
    run_fill(2'd2, 3'b111, 3'b110, 1'b1, 1'b0, 1'b0);
    run_fill(2'd3, 3'b111, 3'b110, 1'b0, 1'b0, 1'b1);
    run_fill(2'($urandom), CW'($urandom), CW'($urandom), 1'b1, 1'b1, 1'b0);

    // Abort a fill with an asynchronous reset, then restart from address 0.
    d0 = done_cnt;
    start_fill(2'd0, 3'b111, 3'b110, 1'b1, s);
    for (int i = 0; i < 20000 && accept_cnt < 1000; i++) @(negedge Clock);
    check("abort_reached_1000", 32'(accept_cnt >= 1000), 32'd1);
    #2;
    Reset = 1'b1;
    #1;
    check("abort_outputs", 32'({oWrEnable, oWrAddress, oWrColor, oBusy, oDone}), 32'd0);
    exp_q.delete();
    rnd_ready = 1'b0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    repeat (20) begin
      @(negedge Clock);
      check("abort_idle", 32'({oWrEnable, oBusy, oDone}), 32'd0);
    end
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    run_fill(2'd0, CW'($urandom), CW'($urandom), 1'b1, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
